// File: rtl/pulse_width_stats_if.sv
// Bus bundle for pulse_width_stats: measurement inputs and statistics outputs.
// The master side drives the signal under test and control; the slave side
// is the measurement block.
interface pulse_width_stats_if #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 16
);
  logic                pulse_in;
  logic                polarity;
  logic                clear;
  logic [N_BITS-1:0]   minimum;
  logic [N_BITS-1:0]   maximum;
  logic [N_BITS-1:0]   last_len;
  logic [CNT_BITS-1:0] pulse_count;
  logic                valid;
  logic                saturated;
  logic                done_stb;

  modport master (
    output pulse_in, polarity, clear,
    input  minimum, maximum, last_len, pulse_count, valid, saturated, done_stb
  );

  modport slave (
    input  pulse_in, polarity, clear,
    output minimum, maximum, last_len, pulse_count, valid, saturated, done_stb
  );
endinterface

// File: rtl/pulse_width_stats.sv
// Pulse width statistics: synchronises an asynchronous strobe, measures the
// width of each active pulse in clk cycles and keeps min/max/last width,
// a saturating pulse count and a sticky saturation flag.
module pulse_width_stats #(
  parameter int N_BITS      = 8,
  parameter int CNT_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  pulse_width_stats_if.slave  bus
);

  localparam logic [N_BITS-1:0]   LEN_MAX   = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic                START_SAT = (N_BITS == 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  function automatic logic [N_BITS-1:0] len_inc_sat(input logic [N_BITS-1:0] v);
    return (v == LEN_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_BITS-1:0] cnt_inc_sat(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   r_pol;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;
  logic                   w_inc;
  logic                   w_end;
  logic                   w_s;
  logic                   w_clr;
  logic                   w_sync_ok;
  logic [N_BITS-1:0]      r_len;
  logic                   r_sat_cur;
  logic                   r_end_p1;
  logic                   r_done_p2;
  logic [N_BITS-1:0]      r_min;
  logic [N_BITS-1:0]      r_max;
  logic [N_BITS-1:0]      r_last;
  logic [CNT_BITS-1:0]    r_cnt;
  logic                   r_valid;
  logic                   r_sat;

  // Active-level view of the synchronised input; a polarity change clears.
  assign w_s       = r_sync[SYNC_STAGES-1] ^ ~bus.polarity;
  assign w_clr     = bus.clear | (bus.polarity != r_pol);
  // Reset zeroes the synchroniser, so its output is not a real sample of the
  // pin until the first post-reset value has reached the last stage. Without
  // this a pin held active through reset would look like a fresh edge.
  assign w_sync_ok = r_sync_vld[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous pin, plus a fill marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_sync_vld <= '0;
    end else begin
      r_sync[0]     <= bus.pulse_in;
      r_sync_vld[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i]     <= r_sync[i-1];
        r_sync_vld[i] <= r_sync_vld[i-1];
      end
    end
  end

  // Remember the polarity seen last cycle to detect a change.
  always_ff @(posedge clk) begin
    r_pol <= bus.polarity;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ARM;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle measurement controls.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_inc       = 1'b0;
    w_end       = 1'b0;
    if (w_clr) begin
      w_state_nxt = ST_ARM;
    end else begin
      case (r_state)
        ST_ARM:  if (w_sync_ok && !w_s) w_state_nxt = ST_IDLE;
        ST_IDLE: if (w_s) begin
                   w_state_nxt = ST_MEAS;
                   w_start     = 1'b1;
                 end
        ST_MEAS: if (w_s) begin
                   w_inc       = 1'b1;
                 end else begin
                   w_state_nxt = ST_IDLE;
                   w_end       = 1'b1;
                 end
        default: w_state_nxt = ST_ARM;
      endcase
    end
  end

  // Stage p0: width counter of the pulse in progress.
  always_ff @(posedge clk) begin
    if (w_start)    r_len <= 1;
    else if (w_inc) r_len <= len_inc_sat(r_len);
  end

  // Per-pulse saturation marker, folded into the sticky flag at pulse end.
  always_ff @(posedge clk) begin
    if (reset || w_clr)                           r_sat_cur <= 1'b0;
    else if (w_start)                             r_sat_cur <= START_SAT;
    else if (w_inc && len_inc_sat(r_len) == LEN_MAX) r_sat_cur <= 1'b1;
    else if (r_end_p1)                            r_sat_cur <= 1'b0;
  end

  // Stage p1: end sample registered; statistics update in the next cycle.
  always_ff @(posedge clk) begin
    if (reset || w_clr) r_end_p1 <= 1'b0;
    else                r_end_p1 <= w_end;
  end

  // Stage p2: fold the finished width into the statistics.
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_min     <= '1;
      r_max     <= '0;
      r_last    <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_done_p2 <= 1'b0;
    end else begin
      r_done_p2 <= r_end_p1;
      if (r_end_p1) begin
        r_last  <= r_len;
        r_cnt   <= cnt_inc_sat(r_cnt);
        r_valid <= 1'b1;
        if (r_len < r_min) r_min <= r_len;
        if (r_len > r_max) r_max <= r_len;
        if (r_sat_cur)     r_sat <= 1'b1;
      end
    end
  end

  assign bus.minimum     = r_min;
  assign bus.maximum     = r_max;
  assign bus.last_len    = r_last;
  assign bus.pulse_count = r_cnt;
  assign bus.valid       = r_valid;
  assign bus.saturated   = r_sat;
  assign bus.done_stb    = r_done_p2;

endmodule

// File: tb/tb_pulse_width_stats.sv
// Bench for pulse_width_stats: two instances (8-bit/2-stage and 4-bit/3-stage
// with a 4-bit count) share one stimulus; a run-length reference model
// predicts each completed pulse and a monitor checks every done_stb.
module tb_pulse_width_stats;

  localparam int NA = 8, CA = 16, SA = 2;
  localparam int NB = 4, CB = 4,  SB = 3;

  typedef struct {
    int cyc;
    int mn, mx, ls, cn;
    bit st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b0;
  logic pol = 1'b1;
  logic clr = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit started = 1'b0;

  // reference model state, one slot per instance
  exp_t expq [2][$];
  bit   hist [2][$];
  bit   need0 [2];
  int   run [2];
  bit   pend [2];
  int   pend_run [2];
  bit   prev_pol [2];
  int   m_min [2], m_max [2], m_last [2], m_cnt [2];
  bit   m_valid [2], m_sat [2];

  pulse_width_stats_if #(.N_BITS(NA), .CNT_BITS(CA)) b8 ();
  pulse_width_stats_if #(.N_BITS(NB), .CNT_BITS(CB)) b4 ();

  assign b8.pulse_in = pin;
  assign b8.polarity = pol;
  assign b8.clear    = clr;
  assign b4.pulse_in = pin;
  assign b4.polarity = pol;
  assign b4.clear    = clr;

  pulse_width_stats #(.N_BITS(NA), .CNT_BITS(CA), .SYNC_STAGES(SA)) u_a (
    .clk(clk), .reset(rst), .bus(b8.slave));
  pulse_width_stats #(.N_BITS(NB), .CNT_BITS(CB), .SYNC_STAGES(SB)) u_b (
    .clk(clk), .reset(rst), .bus(b4.slave));

  always #5 clk = ~clk;

  function automatic int lmax(input int id);
    return (id == 0) ? (1 << NA) - 1 : (1 << NB) - 1;
  endfunction
  function automatic int cmax(input int id);
    return (id == 0) ? (1 << CA) - 1 : (1 << CB) - 1;
  endfunction
  function automatic int sst(input int id);
    return (id == 0) ? SA : SB;
  endfunction

  task automatic stats_reset(input int id);
    m_min[id] = lmax(id); m_max[id] = 0; m_last[id] = 0;
    m_cnt[id] = 0; m_valid[id] = 0; m_sat[id] = 0;
  endtask

  // One clock of the behavioural model: runs of active samples are pulses.
  task automatic model_step(input int id);
    bit clr_eff, have, x, a;
    int w;
    exp_t e;
    if (rst) begin
      hist[id].delete();
      need0[id] = 1; run[id] = 0; pend[id] = 0;
      prev_pol[id] = pol;
      stats_reset(id);
      return;
    end
    clr_eff = clr || (pol != prev_pol[id]);
    prev_pol[id] = pol;
    have = (hist[id].size() == sst(id));
    x = 1'b0;
    if (have) x = hist[id].pop_front();
    hist[id].push_back(pin);
    if (clr_eff) begin
      stats_reset(id);
      pend[id] = 0; run[id] = 0; need0[id] = 1;
      return;
    end
    if (pend[id]) begin
      w = (pend_run[id] > lmax(id)) ? lmax(id) : pend_run[id];
      m_last[id] = w;
      if (m_cnt[id] < cmax(id)) m_cnt[id]++;
      m_valid[id] = 1;
      if (w < m_min[id]) m_min[id] = w;
      if (w > m_max[id]) m_max[id] = w;
      if (pend_run[id] >= lmax(id)) m_sat[id] = 1;
      e.cyc = cyc; e.mn = m_min[id]; e.mx = m_max[id]; e.ls = m_last[id];
      e.cn = m_cnt[id]; e.st = m_sat[id];
      expq[id].push_back(e);
      pend[id] = 0;
    end
    if (have) begin
      a = (x == pol);
      if (need0[id]) begin
        if (!a) need0[id] = 0;
      end else if (a) begin
        run[id]++;
      end else if (run[id] > 0) begin
        pend[id] = 1; pend_run[id] = run[id]; run[id] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  task automatic sample(input int id, output int mn, output int mx, output int ls,
                        output int cn, output bit vl, output bit st, output bit sb);
    if (id == 0) begin
      mn = int'(b8.minimum); mx = int'(b8.maximum); ls = int'(b8.last_len);
      cn = int'(b8.pulse_count); vl = b8.valid; st = b8.saturated; sb = b8.done_stb;
    end else begin
      mn = int'(b4.minimum); mx = int'(b4.maximum); ls = int'(b4.last_len);
      cn = int'(b4.pulse_count); vl = b4.valid; st = b4.saturated; sb = b4.done_stb;
    end
  endtask

  // Monitor: every done_stb pops one predicted report; overdue ones are lost.
  task automatic mon(input int id);
    int mn, mx, ls, cn;
    bit vl, st, sb;
    exp_t e;
    sample(id, mn, mx, ls, cn, vl, st, sb);
    if (sb) begin
      n_vec++;
      if (expq[id].size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done dut%0d cyc %0d: got min %0d max %0d last %0d cnt %0d, no report expected",
                 id, cyc, mn, mx, ls, cn);
      end else begin
        e = expq[id].pop_front();
        if (e.cyc != cyc || mn != e.mn || mx != e.mx || ls != e.ls || cn != e.cn || !vl || st != e.st) begin
          n_fail++;
          $display("FAIL report dut%0d: got cyc %0d min %0d max %0d last %0d cnt %0d valid %0d sat %0d; expected cyc %0d min %0d max %0d last %0d cnt %0d valid 1 sat %0d",
                   id, cyc, mn, mx, ls, cn, vl, st, e.cyc, e.mn, e.mx, e.ls, e.cn, e.st);
        end
      end
    end else if (expq[id].size() > 0 && expq[id][0].cyc <= cyc) begin
      n_vec++;
      n_fail++;
      e = expq[id].pop_front();
      $display("FAIL missing_done dut%0d: no done_stb at cyc %0d, expected last %0d cnt %0d",
               id, e.cyc, e.ls, e.cn);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int id = 0; id < 2; id++) mon(id);
    end
  end

  task automatic check_state(input string tag);
    int mn, mx, ls, cn;
    bit vl, st, sb;
    for (int id = 0; id < 2; id++) begin
      sample(id, mn, mx, ls, cn, vl, st, sb);
      n_vec++;
      if (mn != m_min[id] || mx != m_max[id] || ls != m_last[id] || cn != m_cnt[id] ||
          vl != m_valid[id] || st != m_sat[id]) begin
        n_fail++;
        $display("FAIL %s dut%0d: got min %0d max %0d last %0d cnt %0d valid %0d sat %0d; expected min %0d max %0d last %0d cnt %0d valid %0d sat %0d",
                 tag, id, mn, mx, ls, cn, vl, st,
                 m_min[id], m_max[id], m_last[id], m_cnt[id], m_valid[id], m_sat[id]);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int w, input int g);
    pin = pol;  tick(w);
    pin = ~pol; tick(g);
  endtask

  initial begin
    @(negedge clk);
    rst = 1; pin = 0; pol = 1; clr = 0;
    tick(3);
    rst = 0;
    started = 1;
    check_state("reset_state");
    tick(5);

    // high pulses 5, 3, 9
    pulse(5, 4); pulse(3, 4); pulse(9, 8);
    check_state("high_5_3_9");

    // low pulse of one cycle after a polarity switch
    pol = 0; pin = 1; tick(8);
    pulse(1, 8);
    check_state("low_1");

    // pin already active when reset is released
    rst = 1; pol = 1; pin = 1; tick(3);
    rst = 0; tick(10);
    pin = 0; tick(3);
    pin = 1; tick(7);
    pin = 0; tick(8);
    check_state("active_at_reset");

    // clear over the end cycle of a 6-cycle pulse
    pin = 1; tick(6);
    pin = 0; tick(2);
    clr = 1; tick(3);
    clr = 0; tick(1);
    check_state("clear_at_end");
    tick(3);
    pulse(4, 8);
    check_state("after_clear_4");

    // back-to-back: 2 high / 1 low, ten times
    clr = 1; tick(1); clr = 0; tick(4);
    for (int i = 0; i < 10; i++) pulse(2, 1);
    tick(8);
    check_state("back_to_back");

    // saturation then a short pulse
    pulse(20, 4); pulse(2, 8);
    check_state("saturation");

    // randomized widths, gaps, clears and polarity flips
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        clr = 1; tick(int'($urandom_range(1, 3))); clr = 0;
      end else if (r == 1) begin
        pol = ~pol; pin = ~pol; tick(int'($urandom_range(2, 5)));
      end
      pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)));
    end
    tick(10);
    check_state("random_end");

    for (int id = 0; id < 2; id++) begin
      n_vec++;
      if (expq[id].size() != 0) begin
        n_fail++;
        $display("FAIL pending_reports dut%0d: got %0d outstanding, expected 0", id, expq[id].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
